// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame geometry and bit-period arithmetic.
// Used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS    = 8;
  localparam int IDX_W        = $clog2(DATA_BITS);
  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD     = 9600;

  // Integer divide; the remainder is absorbed as a small per-bit rate error.
  function automatic int bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO, combinational read of the head entry; push/pop take effect on the same edge.
// Pushes while full are dropped (even with a concurrent pop); full is registered.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/uart_tx_fifo_top.sv
// 8N1 UART transmitter fed by a small FIFO; tx falls one cycle after a push into an empty FIFO.
// Frames run back to back while bytes are queued; tx_full signals that further pushes are dropped.
module uart_tx_fifo_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_push,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  uart_state_e    state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           pop, done;
  logic [7:0]     fifo_dout;
  logic           fifo_empty;
  logic           baud_end;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .din_i   (tx_data),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (tx_full),
    .empty_o (fifo_empty)
  );

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          idx_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          tx_d    = shift_q[0];
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          if (idx_q == IDX_LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          done = 1'b1;
          // Chain straight into the next start bit so queued frames have no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            idx_d   = '0;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);
  assign tx_done = done;

endmodule

// File: tb/tb_uart_tx_fifo_top.sv
// Directed bench for uart_tx_fifo_top with a shortened bit period (BIT_CYCLES = 10).
// Frames are checked mid-bit against {stop, data, start} built from the pushed byte.
module tb_uart_tx_fifo_top;

  localparam int BC = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_push;
  logic       tx_full, tx_busy, tx_done, tx;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_fifo_top #(
    .CLK_FREQ   (1000),
    .BAUD       (100),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_push (tx_push),
    .tx_full (tx_full),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a burst of pushes on consecutive cycles; tx_full is checked before each push.
  task automatic push_seq(input logic [7:0] bytes[$], input logic [31:0] full_exp[$]);
    for (int k = 0; k < bytes.size(); k++) begin
      if (full_exp.size() > k) chk($sformatf("full_before_push%0d", k), tx_full, full_exp[k]);
      tx_data = bytes[k];
      tx_push = 1'b1;
      @(negedge clk);
    end
    tx_push = 1'b0;
    tx_data = 8'($urandom);
  endtask

  task automatic wait_fall(output int waited);
    waited = 0;
    while (tx !== 1'b0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] b, input int lat_exp);
    logic [9:0] line;
    int waited, n_done, done_pos;
    line = {1'b1, b, 1'b0};
    n_done = 0;
    done_pos = -1;
    wait_fall(waited);
    chk({tag, "_latency"}, waited, lat_exp);
    chk({tag, "_busy"}, tx_busy, 1'b1);
    for (int i = 0; i < 10 * BC; i++) begin
      if (i % BC == BC / 2) chk($sformatf("%s_bit%0d", tag, i / BC), tx, line[i / BC]);
      if (tx_done === 1'b1) begin
        n_done++;
        done_pos = i;
      end
      @(negedge clk);
    end
    chk({tag, "_done_cnt"}, n_done, 1);
    chk({tag, "_done_pos"}, done_pos, 10 * BC - 1);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    int bad_tx, n_done, n_busy;
    bad_tx = 0; n_done = 0; n_busy = 0;
    for (int i = 0; i < cycles; i++) begin
      if (tx !== 1'b1) bad_tx++;
      if (tx_done !== 1'b0) n_done++;
      if (tx_busy !== 1'b0) n_busy++;
      @(negedge clk);
    end
    chk({tag, "_tx_low_cycles"}, bad_tx, 0);
    chk({tag, "_done_pulses"}, n_done, 0);
    chk({tag, "_busy_cycles"}, n_busy, 0);
  endtask

  initial begin
    int w;
    logic [7:0] q[$];
    logic [31:0] fe[$];
    rst = 1'b1;
    tx_push = 1'b0;
    tx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_full", tx_full, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    rst = 1'b0;
    watch_idle("idle", 200);

    // Single byte 'R'
    q = '{8'h52}; fe = '{32'd0};
    fork
      push_seq(q, fe);
      expect_frame("r52", 8'h52, 2);
    join
    chk("r52_busy_after", tx_busy, 1'b0);
    chk("r52_tx_after", tx, 1'b1);

    // Three contiguous frames
    q = '{8'h52, 8'h55, 8'h4E}; fe = '{32'd0, 32'd0, 32'd0};
    fork
      push_seq(q, fe);
      begin
        expect_frame("b2b0", 8'h52, 2);
        expect_frame("b2b1", 8'h55, 0);
        expect_frame("b2b2", 8'h4E, 0);
      end
    join
    chk("b2b_busy_after", tx_busy, 1'b0);
    watch_idle("b2b_idle", 3 * BC);

    // Overflow: sixth push dropped
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    fe = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
    fork
      begin
        push_seq(q, fe);
        chk("ovf_full_after", tx_full, 1'b1);
      end
      begin
        expect_frame("ovf1", 8'h01, 2);
        expect_frame("ovf2", 8'h02, 0);
        expect_frame("ovf3", 8'h03, 0);
        expect_frame("ovf4", 8'h04, 0);
        expect_frame("ovf5", 8'h05, 0);
      end
    join
    chk("ovf_busy_after", tx_busy, 1'b0);
    chk("ovf_full_end", tx_full, 1'b0);
    watch_idle("ovf_no6", 3 * BC);

    // Reset during data bit 3 of 0x55
    q = '{8'h55}; fe = '{32'd0};
    fork
      push_seq(q, fe);
      wait_fall(w);
    join
    chk("mid_latency", w, 2);
    repeat (4 * BC + BC / 2) @(negedge clk);
    chk("mid_bit3_before_rst", tx, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", tx_busy, 1'b0);
    chk("mid_rst_full", tx_full, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    watch_idle("post_rst", 3 * BC);
    q = '{8'h4E}; fe = '{32'd0};
    fork
      push_seq(q, fe);
      expect_frame("post_rst_4e", 8'h4E, 2);
    join
    chk("post_rst_busy_after", tx_busy, 1'b0);
    watch_idle("final", 2 * BC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
